pipe_run_ctrl: RTL and testbench
================================

# pipe_run_ctrl

Parametrised run controller for the pipelined RISC-V core. It sequences core reset release and run enable, counts cycles and retired instructions, and stops the core on a halt request, a cycle limit or a retire watchdog. It reports a final status code. It sits between the top-level clock/reset and the pipeline wrapper's reset/enable inputs, so simulation and FPGA runs terminate deterministically without relying on fixed bench delays.

## Interface
- CNT_W, 32: width of cycle and retire counters
- RST_CYCLES, 2: cycles the core reset is held after start (≥1)
- MAX_CYCLES, 25: RUN-cycle limit; 0 = unlimited
- WDOG_CYCLES, 8: consecutive RUN cycles without retire before timeout; 0 = disabled

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  level, sampled each edge; begins a run from IDLE or DONE
- halt_req  in  1  core halt (ecall/ebreak) indication, sampled in RUN only
- retire  in  1  one instruction retired this cycle
- core_rst  out  1  reset to pipeline wrapper
- core_en  out  1  clock enable to pipeline wrapper
- cycle_cnt  out  CNT_W  RUN cycles of current/last run
- retire_cnt  out  CNT_W  instructions retired in current/last run
- done  out  1  run finished, status valid
- status  out  2  00 none, 01 halted, 10 cycle limit, 11 watchdog

## Operation
- States: IDLE, RESET, RUN, DONE. All outputs registered (decoded from next state).
- rst asserted (any time, including mid-run): state IDLE, core_rst=1, core_en=0, cycle_cnt=0, retire_cnt=0, done=0, status=00, internal reset and idle counters 0.
- IDLE: core_rst=1, core_en=0. start=1 → RESET.
- Entering RESET (from IDLE or DONE): cycle_cnt, retire_cnt, idle counter cleared; done=0; status=00.
- RESET: core_rst=1, core_en=0 for exactly RST_CYCLES cycles, then RUN.
- RUN: core_rst=0, core_en=1. cycle_cnt +1 each cycle; retire_cnt +1 when retire=1; idle counter cleared on retire, else +1.
- RUN exit, evaluated each edge, priority halt > limit > watchdog:
  - halt_req=1 → DONE, status 01.
  - MAX_CYCLES≠0 and incremented cycle_cnt == MAX_CYCLES → DONE, status 10.
  - WDOG_CYCLES≠0 and incremented idle counter == WDOG_CYCLES → DONE, status 11.
- The terminating cycle is counted: its cycle increment and any retire are included.
- DONE: core_en=0, core_rst=0 (core state frozen for inspection), done=1, counters and status held. start=1 → RESET (restart).
- start ignored in RESET and RUN. retire and halt_req ignored outside RUN.
- Counters saturate at 2^CNT_W−1; no wrap.

## Timing
- start sampled high at edge E (state IDLE): core_rst=1 through edge E+RST_CYCLES−1; at edge E+RST_CYCLES, core_rst=0 and core_en=1.
- Unlimited halt-free run with MAX_CYCLES=N: core_en high for exactly N cycles; done=1, core_en=0 from the edge where cycle_cnt becomes N.
- halt_req high at RUN edge H: done=1, status=01, core_en=0 visible after H; cycle_cnt includes cycle H.
- done rises one edge after the terminating condition is sampled; status and done change on the same edge.
- Restart from DONE: done falls and counters clear on the edge start is sampled; RUN resumes RST_CYCLES edges later.
- rst deassertion is not synchronised internally; the first start is sampled on the first rising edge after rst falls.

## Test plan
- Defaults, retire=1 every cycle, no halt, start pulse → core_rst high 2 cycles, core_en high 25 cycles, done=1, status=10, cycle_cnt=25, retire_cnt=25.
- retire every cycle, halt_req pulsed on 10th RUN cycle → done=1, status=01, cycle_cnt=10, retire_cnt=10, core_en low next cycle.
- retire for 5 RUN cycles then held 0 → status=11 after 8 idle cycles, cycle_cnt=13, retire_cnt=5.
- halt_req and cycle limit on the same (25th) cycle with retire=1 → status=01, cycle_cnt=25, retire_cnt=25.
- rst asserted asynchronously mid-RUN (cycle 7) → outputs immediately core_rst=1, core_en=0, counters 0, done=0, status=00; start → normal run restarts.
- In DONE, assert start → done falls, counters clear, 2 reset cycles, new run reproduces first scenario's values; start held during RUN has no effect.

Source files
------------

// File: rtl/pipe_run_ctrl.sv
// Run controller for the pipelined core: sequences core reset/enable, counts
// RUN cycles and retirements, and stops on halt, cycle limit or retire watchdog.
module pipe_run_ctrl #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned RST_CYCLES  = 2,
  parameter int unsigned MAX_CYCLES  = 25,
  parameter int unsigned WDOG_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt_req,
  input  logic             retire,
  output logic             core_rst,
  output logic             core_en,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             done,
  output logic [1:0]       status
);

  localparam int unsigned RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RW-1:0]    RST_LAST = RW'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] WDOG_C   = CNT_W'(WDOG_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    ST_NONE  = 2'b00,
    ST_HALT  = 2'b01,
    ST_LIMIT = 2'b10,
    ST_WDOG  = 2'b11
  } status_t;

  state_t           state, state_n;
  status_t          status_q, status_n;
  logic [RW-1:0]    rcnt, rcnt_n;
  logic [CNT_W-1:0] cyc_n, ret_n, idle_cnt, idle_n;
  logic [CNT_W-1:0] cyc_inc, ret_inc, idle_inc;
  logic             launch;

  // Saturating increments: counters stick at all-ones instead of wrapping.
  assign cyc_inc  = (&cycle_cnt)  ? cycle_cnt  : cycle_cnt  + 1'b1;
  assign ret_inc  = (&retire_cnt) ? retire_cnt : retire_cnt + 1'b1;
  assign idle_inc = (&idle_cnt)   ? idle_cnt   : idle_cnt   + 1'b1;

  always_comb begin
    state_n  = state;
    status_n = status_q;
    rcnt_n   = rcnt;
    cyc_n    = cycle_cnt;
    ret_n    = retire_cnt;
    idle_n   = idle_cnt;
    launch   = 1'b0;

    unique case (state)
      S_IDLE:  launch = start;
      S_RESET: begin
        if (rcnt == RST_LAST) state_n = S_RUN;
        else                  rcnt_n  = rcnt + 1'b1;
      end
      S_RUN: begin
        cyc_n = cyc_inc;
        if (retire) begin
          ret_n  = ret_inc;
          idle_n = '0;
        end else begin
          idle_n = idle_inc;
        end
        // Exit priority: halt, then cycle limit, then watchdog.
        if (halt_req) begin
          state_n  = S_DONE;
          status_n = ST_HALT;
        end else if ((MAX_CYCLES != 0) && (cyc_inc == MAX_C)) begin
          state_n  = S_DONE;
          status_n = ST_LIMIT;
        end else if ((WDOG_CYCLES != 0) && !retire && (idle_inc == WDOG_C)) begin
          state_n  = S_DONE;
          status_n = ST_WDOG;
        end
      end
      S_DONE:  launch = start;
      default: state_n = S_IDLE;
    endcase

    if (launch) begin
      state_n  = S_RESET;
      status_n = ST_NONE;
      rcnt_n   = '0;
      cyc_n    = '0;
      ret_n    = '0;
      idle_n   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      status_q   <= ST_NONE;
      rcnt       <= '0;
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      idle_cnt   <= '0;
      core_rst   <= 1'b1;
      core_en    <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      status_q   <= status_n;
      rcnt       <= rcnt_n;
      cycle_cnt  <= cyc_n;
      retire_cnt <= ret_n;
      idle_cnt   <= idle_n;
      core_rst   <= (state_n == S_IDLE) || (state_n == S_RESET);
      core_en    <= (state_n == S_RUN);
      done       <= (state_n == S_DONE);
    end
  end

  assign status = status_q;

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Directed bench for pipe_run_ctrl: scenario table plus hand-written
// async-reset and saturation sequences.
module tb_pipe_run_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, halt_req, retire;
  logic        core_rst, core_en, done;
  logic [31:0] cycle_cnt, retire_cnt;
  logic [1:0]  status;

  // Narrow instance: 4-bit counters, 1 reset cycle, no limit, no watchdog.
  logic        s_start, s_halt, s_retire;
  logic        s_core_rst, s_core_en, s_done;
  logic [3:0]  s_cyc, s_ret;
  logic [1:0]  s_status;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_run_ctrl #(.CNT_W(32), .RST_CYCLES(2), .MAX_CYCLES(25), .WDOG_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req), .retire(retire),
    .core_rst(core_rst), .core_en(core_en), .cycle_cnt(cycle_cnt),
    .retire_cnt(retire_cnt), .done(done), .status(status)
  );

  pipe_run_ctrl #(.CNT_W(4), .RST_CYCLES(1), .MAX_CYCLES(0), .WDOG_CYCLES(0)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .halt_req(s_halt), .retire(s_retire),
    .core_rst(s_core_rst), .core_en(s_core_en), .cycle_cnt(s_cyc),
    .retire_cnt(s_ret), .done(s_done), .status(s_status)
  );

  typedef struct {
    string      name;
    int         ret_until;   // retire=1 on RUN cycles 1..ret_until
    int         halt_at;     // halt_req on this RUN cycle, 0 = never
    bit         hold_start;  // keep start high through RESET and most of RUN
    int         exp_rst;
    int         exp_en;
    logic [1:0] exp_status;
    int         exp_cyc;
    int         exp_ret;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_scn(input vec_t v);
    int nrst = 0;
    int nen  = 0;
    start = 1'b1;
    tick();
    start = v.hold_start;
    chk({v.name, ".done_clr"}, done, 0);
    chk({v.name, ".cyc_clr"}, cycle_cnt, 0);
    chk({v.name, ".ret_clr"}, retire_cnt, 0);
    chk({v.name, ".status_clr"}, status, 0);
    while (core_rst && nrst < 50) begin
      nrst++;
      tick();
    end
    while (core_en && nen < 200) begin
      nen++;
      retire   = (nen <= v.ret_until);
      halt_req = (nen == v.halt_at);
      start    = v.hold_start && (nen < 20);
      tick();
    end
    retire   = 1'b0;
    halt_req = 1'b0;
    start    = 1'b0;
    chk({v.name, ".rst_cycles"}, nrst, v.exp_rst);
    chk({v.name, ".en_cycles"}, nen, v.exp_en);
    chk({v.name, ".done"}, done, 1);
    chk({v.name, ".core_rst"}, core_rst, 0);
    chk({v.name, ".status"}, status, v.exp_status);
    chk({v.name, ".cycle_cnt"}, cycle_cnt, v.exp_cyc);
    chk({v.name, ".retire_cnt"}, retire_cnt, v.exp_ret);
  endtask

  initial begin
    tbl[0] = '{"limit",     1000, 0,  1'b0, 2, 25, 2'b10, 25, 25};
    tbl[1] = '{"halt10",    1000, 10, 1'b0, 2, 10, 2'b01, 10, 10};
    tbl[2] = '{"wdog",      5,    0,  1'b0, 2, 13, 2'b11, 13, 5};
    tbl[3] = '{"halt_lim",  1000, 25, 1'b0, 2, 25, 2'b01, 25, 25};
    tbl[4] = '{"hold_start",1000, 0,  1'b1, 2, 25, 2'b10, 25, 25};

    rst = 1'b1; start = 1'b0; halt_req = 1'b0; retire = 1'b0;
    s_start = 1'b0; s_halt = 1'b0; s_retire = 1'b0;
    repeat (2) tick();
    chk("reset.core_rst", core_rst, 1);
    chk("reset.core_en", core_en, 0);
    chk("reset.done", done, 0);
    chk("reset.status", status, 0);
    chk("reset.cycle_cnt", cycle_cnt, 0);
    rst = 1'b0;
    tick();
    chk("idle.core_rst", core_rst, 1);
    chk("idle.done", done, 0);

    for (int i = 0; i < 5; i++) run_scn(tbl[i]);

    // Async reset on the 7th RUN cycle, checked before the next clock edge.
    begin
      int n = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      while (!core_en && n < 50) begin
        n++;
        tick();
      end
      chk("arst.reached_run", core_en, 1);
      retire = 1'b1;
      repeat (6) tick();
      chk("arst.cyc_before", cycle_cnt, 6);
      #2 rst = 1'b1;
      #1;
      chk("arst.core_rst", core_rst, 1);
      chk("arst.core_en", core_en, 0);
      chk("arst.cycle_cnt", cycle_cnt, 0);
      chk("arst.retire_cnt", retire_cnt, 0);
      chk("arst.done", done, 0);
      chk("arst.status", status, 0);
      retire = 1'b0;
      #1 rst = 1'b0;
      tick();
    end
    run_scn(tbl[0]);

    // Saturation, unlimited cycles and disabled watchdog on the narrow instance.
    begin
      int nrst = 0;
      int nen  = 0;
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      while (s_core_rst && nrst < 50) begin
        nrst++;
        tick();
      end
      while (s_core_en && nen < 100) begin
        nen++;
        s_halt = (nen == 20);
        tick();
      end
      s_halt = 1'b0;
      chk("sat.rst_cycles", nrst, 1);
      chk("sat.en_cycles", nen, 20);
      chk("sat.done", s_done, 1);
      chk("sat.status", s_status, 2'b01);
      chk("sat.cycle_cnt", s_cyc, 15);
      chk("sat.retire_cnt", s_ret, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
